// File: rtl/pp_color_classifier.sv
// pp_color_classifier: RGB565 multi-class window classifier with frame-synchronous config and per-class hit counters
module pp_color_classifier #(
   parameter int N_CLASSES = 4,
   parameter int CNT_W     = 20,
   parameter int CLS_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_rstn,
   input  logic                         i_valid,
   output logic                         o_ready,
   input  logic [15:0]                  i_pixel,
   input  logic                         i_sof,
   input  logic                         i_eol,
   output logic                         o_valid,
   input  logic                         i_ready,
   output logic                         o_hit,
   output logic [CLS_W-1:0]             o_class,
   output logic [N_CLASSES-1:0]         o_match_mask,
   output logic                         o_sof,
   output logic                         o_eol,
   input  logic                         i_cfg_we,
   input  logic [CLS_W-1:0]             i_cfg_class,
   input  logic                         i_cfg_en,
   input  logic [31:0]                  i_cfg_data,
   output logic [N_CLASSES*CNT_W-1:0]   o_count,
   output logic                         o_count_valid
);
   localparam logic [31:0] DEF_CFG = {5'd31, 5'd27, 6'd12, 6'd0, 5'd8, 5'd0};

   logic [N_CLASSES-1:0]         sh_en_q, act_en_q, match_d, s1_mask_q, out_mask_q;
   logic [31:0]                  sh_cfg_q [N_CLASSES];
   logic [31:0]                  act_cfg_q [N_CLASSES];
   logic [CNT_W-1:0]             cnt_q [N_CLASSES];
   logic [N_CLASSES*CNT_W-1:0]   cnt_flat, count_q;
   logic [CLS_W-1:0]             enc_d, out_class_q;
   logic                         s1_valid_q, s1_sof_q, s1_eol_q;
   logic                         out_valid_q, out_hit_q, out_sof_q, out_eol_q, count_valid_q;
   logic                         adv, sof_acc, xfer;

   assign adv           = !out_valid_q || i_ready;
   assign sof_acc       = i_valid && adv && i_sof;
   assign xfer          = out_valid_q && i_ready;
   assign o_ready       = adv;
   assign o_valid       = out_valid_q;
   assign o_hit         = out_hit_q;
   assign o_class       = out_class_q;
   assign o_match_mask  = out_mask_q;
   assign o_sof         = out_sof_q;
   assign o_eol         = out_eol_q;
   assign o_count       = count_q;
   assign o_count_valid = count_valid_q;

   // The SOF pixel sees the shadow set directly, since it becomes active on the same edge
   for (genvar k = 0; k < N_CLASSES; k++) begin : g_cmp
      logic [31:0] c;
      logic        e;
      assign c = sof_acc ? sh_cfg_q[k] : act_cfg_q[k];
      assign e = sof_acc ? sh_en_q[k] : act_en_q[k];
      assign match_d[k] = e && i_pixel[15:11] >= c[26:22] && i_pixel[15:11] <= c[31:27]
                            && i_pixel[10:5] >= c[15:10] && i_pixel[10:5] <= c[21:16]
                            && i_pixel[4:0] >= c[4:0] && i_pixel[4:0] <= c[9:5];
      assign cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
   end

   // Lowest set bit of the stage-1 mask wins
   always_comb begin
      enc_d = '0;
      for (int k = N_CLASSES - 1; k >= 0; k--) if (s1_mask_q[k]) enc_d = CLS_W'(k);
   end

   // Shadow writes from the config port; shadow-to-active copy on an accepted SOF uses the pre-write shadow
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         sh_en_q  <= N_CLASSES'(1);
         act_en_q <= N_CLASSES'(1);
         for (int k = 0; k < N_CLASSES; k++) begin
            sh_cfg_q[k]  <= (k == 0) ? DEF_CFG : '0;
            act_cfg_q[k] <= (k == 0) ? DEF_CFG : '0;
         end
      end else begin
         for (int k = 0; k < N_CLASSES; k++) begin
            if (i_cfg_we && i_cfg_class == CLS_W'(k)) begin
               sh_en_q[k]  <= i_cfg_en;
               sh_cfg_q[k] <= i_cfg_data;
            end
            if (sof_acc) act_cfg_q[k] <= sh_cfg_q[k];
         end
         if (sof_acc) act_en_q <= sh_en_q;
      end
   end

   // Two-stage pipeline sharing one advance enable: compare results, then priority encode
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         s1_valid_q  <= 1'b0;
         s1_mask_q   <= '0;
         s1_sof_q    <= 1'b0;
         s1_eol_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_hit_q   <= 1'b0;
         out_class_q <= '0;
         out_mask_q  <= '0;
         out_sof_q   <= 1'b0;
         out_eol_q   <= 1'b0;
      end else if (adv) begin
         s1_valid_q  <= i_valid;
         s1_mask_q   <= i_valid ? match_d : '0;
         s1_sof_q    <= i_valid && i_sof;
         s1_eol_q    <= i_valid && i_eol;
         out_valid_q <= s1_valid_q;
         out_hit_q   <= |s1_mask_q;
         out_class_q <= enc_d;
         out_mask_q  <= s1_mask_q;
         out_sof_q   <= s1_sof_q;
         out_eol_q   <= s1_eol_q;
      end
   end

   // Saturating per-class hit counters; an SOF transfer publishes them and restarts with its own hit
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         for (int k = 0; k < N_CLASSES; k++) cnt_q[k] <= '0;
         count_q       <= '0;
         count_valid_q <= 1'b0;
      end else begin
         count_valid_q <= xfer && out_sof_q;
         if (xfer && out_sof_q) count_q <= cnt_flat;
         for (int k = 0; k < N_CLASSES; k++) begin
            if (xfer && out_sof_q)
               cnt_q[k] <= (out_hit_q && out_class_q == CLS_W'(k)) ? CNT_W'(1) : '0;
            else if (xfer && out_hit_q && out_class_q == CLS_W'(k) && cnt_q[k] != '1)
               cnt_q[k] <= cnt_q[k] + CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_pp_color_classifier.sv
// tb_pp_color_classifier: directed stimulus with a reference-model scoreboard for pp_color_classifier
module tb_pp_color_classifier;
   localparam int N = 4;
   localparam int CW = 3;
   localparam logic [31:0] DEF = {5'd31, 5'd27, 6'd12, 6'd0, 5'd8, 5'd0};

   logic clk = 1'b0, rstn = 1'b0, i_valid = 1'b0, i_sof = 1'b0, i_eol = 1'b0;
   logic ready = 1'b1, cfg_we = 1'b0, cfg_en = 1'b0;
   logic [15:0] pixel = '0;
   logic [1:0]  cfg_class = '0;
   logic [31:0] cfg_data = '0;
   logic o_ready, o_valid, o_hit, o_sof, o_eol, o_count_valid;
   logic [1:0]  o_class;
   logic [3:0]  o_mask;
   logic [N*CW-1:0] o_count;

   int n_chk = 0, n_fail = 0, rmode = 0;

   logic [3:0]  sh_en, act_en;
   logic [31:0] sh_cfg [N];
   logic [31:0] act_cfg [N];
   logic [8:0]  sb [$];
   int          cnt_m [N];
   logic [N*CW-1:0] pub_exp = '0;
   logic        cv_due = 1'b0, stalled = 1'b0;
   logic [8:0]  obs_m, held_m, e_m;

   pp_color_classifier #(.N_CLASSES(N), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(o_ready), .i_pixel(pixel),
      .i_sof(i_sof), .i_eol(i_eol), .o_valid(o_valid), .i_ready(ready), .o_hit(o_hit),
      .o_class(o_class), .o_match_mask(o_mask), .o_sof(o_sof), .o_eol(o_eol),
      .i_cfg_we(cfg_we), .i_cfg_class(cfg_class), .i_cfg_en(cfg_en), .i_cfg_data(cfg_data),
      .o_count(o_count), .o_count_valid(o_count_valid)
   );

   always #5 clk = ~clk;

   // Downstream ready: 0 always high, 1 toggles every cycle, 2 held low
   always @(posedge clk) begin
      #1;
      ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ~ready : 1'b0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] px(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
      return {r, g, b};
   endfunction

   function automatic logic [31:0] win(input logic [4:0] rl, input logic [4:0] rh, input logic [5:0] gl,
                                       input logic [5:0] gh, input logic [4:0] bl, input logic [4:0] bh);
      return {rh, rl, gh, gl, bh, bl};
   endfunction

   task automatic model_reset();
      sh_en  = 4'b0001;
      act_en = 4'b0001;
      for (int k = 0; k < N; k++) begin
         sh_cfg[k]  = (k == 0) ? DEF : '0;
         act_cfg[k] = (k == 0) ? DEF : '0;
      end
   endtask

   task automatic send(input logic [15:0] p, input logic s, input logic e);
      logic acc;
      logic [3:0] m;
      logic [1:0] c;
      logic [31:0] w;
      i_valid = 1'b1; pixel = p; i_sof = s; i_eol = e;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
      end
      chk("accept", 64'(acc), 64'(1));
      if (s) begin
         act_en = sh_en;
         for (int k = 0; k < N; k++) act_cfg[k] = sh_cfg[k];
      end
      for (int k = 0; k < N; k++) begin
         w = act_cfg[k];
         m[k] = act_en[k] && p[15:11] >= w[26:22] && p[15:11] <= w[31:27] && p[10:5] >= w[15:10]
                && p[10:5] <= w[21:16] && p[4:0] >= w[4:0] && p[4:0] <= w[9:5];
      end
      c = '0;
      for (int k = N - 1; k >= 0; k--) if (m[k]) c = 2'(k);
      sb.push_back({|m, c, m, s, e});
      #1;
      i_valid = 1'b0; i_sof = 1'b0; i_eol = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] k, input logic en, input logic [31:0] d);
      cfg_we = 1'b1; cfg_class = k; cfg_en = en; cfg_data = d;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      sh_en[k] = en; sh_cfg[k] = d;
   endtask

   task automatic send_cfg(input logic [15:0] p, input logic [1:0] k, input logic en, input logic [31:0] d);
      cfg_we = 1'b1; cfg_class = k; cfg_en = en; cfg_data = d;
      send(p, 1'b1, 1'b0);
      cfg_we = 1'b0;
      sh_en[k] = en; sh_cfg[k] = d;
   endtask

   task automatic flush();
      repeat (6) @(posedge clk);
      #1;
   endtask

   // Output monitor: scoreboard compare, stall stability, and count-publication model
   always @(negedge clk) begin
      if (!rstn) begin
         sb.delete();
         for (int k = 0; k < N; k++) cnt_m[k] = 0;
         cv_due = 1'b0;
         stalled = 1'b0;
      end else begin
         obs_m = {o_hit, o_class, o_mask, o_sof, o_eol};
         chk("count_valid", 64'(o_count_valid), 64'(cv_due));
         if (cv_due) chk("count", 64'(o_count), 64'(pub_exp));
         cv_due = 1'b0;
         if (stalled) chk("stall_hold", 64'({o_valid, obs_m}), 64'({1'b1, held_m}));
         stalled = o_valid && !ready;
         held_m = obs_m;
         if (o_valid && ready) begin
            chk("beat_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
               e_m = sb.pop_front();
               chk("beat", 64'(obs_m), 64'(e_m));
               if (e_m[1]) begin
                  for (int k = 0; k < N; k++) pub_exp[k*CW +: CW] = CW'(cnt_m[k]);
                  cv_due = 1'b1;
                  for (int k = 0; k < N; k++) cnt_m[k] = 0;
                  if (e_m[8]) cnt_m[e_m[7:6]] = 1;
               end else if (e_m[8] && cnt_m[e_m[7:6]] < (1 << CW) - 1) begin
                  cnt_m[e_m[7:6]]++;
               end
            end
         end
      end
   end

   initial begin
      logic seen;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out", 64'({o_valid, o_hit, o_class, o_mask, o_sof, o_eol, o_count_valid}), 64'(0));
      chk("rst_count", 64'(o_count), 64'(0));
      @(posedge clk);
      #1 rstn = 1'b1;
      // Reset defaults and two-register latency on an empty pipe
      send(16'hF800, 1'b1, 1'b0);
      @(negedge clk);
      chk("lat_stage1", 64'(o_valid), 64'(0));
      @(negedge clk);
      chk("lat_stage2", 64'({o_valid, o_hit, o_class}), 64'({1'b1, 1'b1, 2'd0}));
      @(posedge clk);
      #1;
      send(16'hFFFF, 1'b0, 1'b0);
      // Inclusive boundaries of the default class-0 window
      send(px(5'd27, 6'd12, 5'd8), 1'b0, 1'b0);
      send(px(5'd26, 6'd12, 5'd8), 1'b0, 1'b0);
      send(px(5'd27, 6'd13, 5'd8), 1'b0, 1'b0);
      send(px(5'd27, 6'd12, 5'd9), 1'b0, 1'b0);
      send(px(5'd31, 6'd0, 5'd0), 1'b0, 1'b1);
      flush();
      // Overlapping class 1 and an inverted class-3 window
      cfg(2'd1, 1'b1, DEF);
      cfg(2'd3, 1'b1, win(5'd20, 5'd10, 6'd0, 6'd63, 5'd0, 5'd31));
      send(16'hF800, 1'b1, 1'b0);
      send(px(5'd15, 6'd0, 5'd0), 1'b0, 1'b0);
      flush();
      chk("prio_sb_drained", 64'(sb.size()), 64'(0));
      // Mid-frame write stays in the shadow until the next SOF
      cfg(2'd2, 1'b1, win(5'd0, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31));
      send(16'h07E0, 1'b0, 1'b0);
      send(16'h07E0, 1'b1, 1'b0);
      // Write coincident with SOF: copy takes the pre-write shadow
      send_cfg(16'h07E0, 2'd2, 1'b0, win(5'd0, 5'd31, 6'd0, 6'd63, 5'd0, 5'd31));
      send(16'h07E0, 1'b1, 1'b0);
      flush();
      // Backpressure with ready toggling every cycle
      rmode = 1;
      for (int i = 0; i < 8; i++) send(px(5'(24 + i), 6'(i * 3), 5'(i)), 1'b0, 1'(i == 7));
      repeat (20) @(posedge clk);
      rmode = 0;
      flush();
      chk("bp_sb_drained", 64'(sb.size()), 64'(0));
      // Counter saturation: 10 class-0 hits in one frame
      send(16'hF800, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) send(16'hF800, 1'b0, 1'b0);
      send(16'hF800, 1'b1, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 10 && !seen; t++) begin
         @(negedge clk);
         seen = o_count_valid;
      end
      chk("sat_pulse_seen", 64'(seen), 64'(1));
      chk("sat_count0", 64'(o_count[2:0]), 64'(7));
      @(negedge clk);
      chk("sat_pulse_width", 64'(o_count_valid), 64'(0));
      @(posedge clk);
      #1;
      flush();
      // Reset mid-frame with beats stalled in flight
      rmode = 2;
      send(16'hF800, 1'b0, 1'b0);
      send(16'hF800, 1'b0, 1'b0);
      #1 rstn = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      rmode = 0;
      @(negedge clk);
      chk("midrst_out", 64'({o_valid, o_hit, o_class, o_mask, o_count_valid}), 64'(0));
      chk("midrst_count", 64'(o_count), 64'(0));
      @(posedge clk);
      #1 rstn = 1'b1;
      send(16'hF800, 1'b1, 1'b0);
      send(16'hF800, 1'b0, 1'b0);
      send(16'hF800, 1'b1, 1'b0);
      flush();
      chk("final_sb_drained", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
